// File: rtl/data_ram_arbiter.sv
// rtl/data_ram_arbiter.sv - round-robin two-master arbiter and single-cycle sequencer for data_ram
module data_ram_arbiter #(
    parameter int DEPTH = 1024,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    output logic          m0_gnt,
    output logic          m0_ack,
    output logic          m0_err,
    output logic [31:0]   m0_rdata,
    output logic          m1_gnt,
    output logic          m1_ack,
    output logic          m1_err,
    output logic [31:0]   m1_rdata,
    output logic          ram_we,
    output logic          ram_re,
    output logic [AW-1:0] ram_a,
    output logic [31:0]   ram_wd,
    input  logic [31:0]   ram_rd
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

    state_t        state;
    logic          owner;
    logic          last;
    logic          cmd_we;
    logic          cmd_bad;

    logic          in_access;
    logic          el0;
    logic          el1;
    logic          win_valid;
    logic          win;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [31:0]   win_wdata;
    logic          win_bad;

    // The owner of the current access is masked so it cannot be granted twice in a row.
    always_comb begin
        in_access = (state == ACCESS);
        el0       = m0_req & ~(in_access & ~owner);
        el1       = m1_req & ~(in_access & owner);
        win_valid = el0 | el1;
        win       = (el0 & el1) ? ~last : el1;
        win_we    = win ? m1_we    : m0_we;
        win_addr  = win ? m1_addr  : m0_addr;
        win_wdata = win ? m1_wdata : m0_wdata;
        win_bad   = (win_addr[1:0] != 2'b00) || ({2'b00, win_addr[AW-1:2]} >= DEPTH_W);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= 1'b0;
            last     <= 1'b1;
            cmd_we   <= 1'b0;
            cmd_bad  <= 1'b0;
            ram_a    <= '0;
            ram_wd   <= '0;
            ram_we   <= 1'b0;
            ram_re   <= 1'b0;
            m0_gnt   <= 1'b0;
            m1_gnt   <= 1'b0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_err   <= 1'b0;
            m1_err   <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else begin
            m0_ack <= in_access & ~owner;
            m1_ack <= in_access & owner;
            m0_err <= in_access & ~owner & cmd_bad;
            m1_err <= in_access & owner & cmd_bad;
            // Stores leave the owner's read data untouched; bad loads return zero.
            if (in_access && !cmd_we) begin
                if (owner) begin
                    m1_rdata <= cmd_bad ? 32'h0 : ram_rd;
                end else begin
                    m0_rdata <= cmd_bad ? 32'h0 : ram_rd;
                end
            end
            if (win_valid) begin
                state   <= ACCESS;
                owner   <= win;
                last    <= win;
                cmd_we  <= win_we;
                cmd_bad <= win_bad;
                ram_a   <= win_addr;
                ram_wd  <= win_wdata;
                ram_we  <= win_we & ~win_bad;
                ram_re  <= ~win_we & ~win_bad;
                m0_gnt  <= ~win;
                m1_gnt  <= win;
            end else begin
                state   <= IDLE;
                ram_we  <= 1'b0;
                ram_re  <= 1'b0;
                m0_gnt  <= 1'b0;
                m1_gnt  <= 1'b0;
            end
        end
    end

endmodule
